mem_port_arbiter: RTL

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the pipelined ARM core.
- Serialises the two requesters, inserts the fixed memory latency, and returns per-requester stall and ack signals for the hazard/stall logic.
- Sits between the pipeline stages and the memory model and replaces their separate instruction and data memories.

---
 rtl/arm_mem_arb_pkg.sv | 28 ++
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/arm_mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// The MEM_ARB_ROUND_ROBIN_EN build uses OWNER_* to track the last grant.
package arm_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  typedef logic owner_t;
  localparam owner_t OWNER_INSTR = 1'b0;
  localparam owner_t OWNER_DATA  = 1'b1;

  // Wait counter load value: LATENCY busy cycles means the counter starts at LATENCY-1.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned latency);
    int unsigned w_val;
    w_val = latency - 1;
    return w_val[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the memory busy phase.
// Load has priority over decrement; decrement saturates at zero.
module mem_wait_counter
  import arm_mem_arb_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage accesses onto one single-port memory with fixed latency.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate winners under contention instead of data-first.
module mem_port_arbiter
  import arm_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = 2  // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_ack,
  output logic              instr_stall,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ack,
  output logic              data_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_instr_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              w_idle;
  logic              w_grant_data;
  logic              w_grant_instr;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  assign w_idle = (r_state == IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t r_last_owner;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    w_grant_data  = 1'b0;
    w_grant_instr = 1'b0;
    if (w_idle) begin
      if (data_req && instr_req) begin
        w_grant_data  = (r_last_owner == OWNER_INSTR);
        w_grant_instr = (r_last_owner == OWNER_DATA);
      end else begin
        w_grant_data  = data_req;
        w_grant_instr = instr_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_owner <= OWNER_INSTR;
    end else if (w_grant_data) begin
      r_last_owner <= OWNER_DATA;
    end else if (w_grant_instr) begin
      r_last_owner <= OWNER_INSTR;
    end
  end
`else
  // Data wins: the MEM-stage instruction is older than the one being fetched.
  always_comb begin
    w_grant_data  = w_idle && data_req;
    w_grant_instr = w_idle && instr_req && !data_req;
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_data) begin
          w_state_next = BUSY_D;
          w_cnt_load   = 1'b1;
        end else if (w_grant_instr) begin
          w_state_next = BUSY_I;
          w_cnt_load   = 1'b1;
        end
      end
      BUSY_I: begin
        if (w_cnt_zero) w_state_next = DONE_I;
        else            w_cnt_dec    = 1'b1;
      end
      BUSY_D: begin
        if (w_cnt_zero) w_state_next = DONE_D;
        else            w_cnt_dec    = 1'b1;
      end
      DONE_I, DONE_D: w_state_next = IDLE;
      default:        w_state_next = IDLE;
    endcase
  end

  mem_wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (wait_load(LATENCY)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request fields are captured only at grant; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant_data) begin
      r_addr  <= data_addr;
      r_wdata <= data_wdata;
      r_we    <= data_we;
    end else if (w_grant_instr) begin
      r_addr  <= instr_addr;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else if (w_cnt_zero) begin
      if (r_state == BUSY_I) begin
        r_instr_rdata <= mem_rdata;
      end else if (r_state == BUSY_D) begin
        r_data_rdata  <= r_we ? '0 : mem_rdata;
      end
    end
  end

  // Strobes decode straight from the state flop so an async reset drops them at once.
  assign mem_en      = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign mem_we      = (r_state == BUSY_D) && r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign instr_ack   = (r_state == DONE_I);
  assign data_ack    = (r_state == DONE_D);
  assign instr_rdata = r_instr_rdata;
  assign data_rdata  = r_data_rdata;
  assign instr_stall = instr_req && !instr_ack;
  assign data_stall  = data_req && !data_ack;

endmodule
